sop_gate_array: RTL and testbench

- Parametrised, registered successor to the fixed two-channel AND-OR gate chip.
- Provides CH independent sum-of-products channels. Each channel ORs TERMS AND-terms of TIN inputs.
- Per-term input masks are runtime-programmable, and each channel has an optional output inversion (AOI mode).
- Adds a registered output, rising-edge pulses, saturating toggle counters and a hold control. It serves as the generic glue-logic tile for chip-emulation benches.

---
 rtl/sop_gate_array_pkg.sv | 21 ++
 rtl/sop_channel.sv | 33 +++
 rtl/sop_gate_array.sv | 104 ++++++++++
 tb/tb_sop_gate_array.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sop_gate_array_pkg.sv
// Shared helpers for the sum-of-products gate array.
// Index widths, mask reset constant and in_vec bit mapping.
package sop_gate_array_pkg;

  localparam logic [63:0] MASK_RST = '1;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int bit_idx(
    input int c,
    input int t,
    input int b,
    input int terms,
    input int tin
  );
    return c * terms * tin + t * tin + b;
  endfunction

endpackage

// File: rtl/sop_channel.sv
// One sum-of-products channel: masked AND-terms, OR, optional invert.
// Purely combinational; state lives in the top.
module sop_channel
  import sop_gate_array_pkg::*;
#(
  parameter int TERMS = 2,
  parameter int TIN   = 3
) (
  input  logic [TERMS*TIN-1:0] in_i,
  input  logic [TERMS*TIN-1:0] mask_i,
  input  logic                 inv_i,
  output logic                 ynext_o
);

  logic [TERMS-1:0] term;
  logic [TIN-1:0]   m;
  logic [TIN-1:0]   s;

  always_comb begin
    term = '0;
    m    = '0;
    s    = '0;
    for (int t = 0; t < TERMS; t++) begin
      m = mask_i[bit_idx(0, t, 0, TERMS, TIN) +: TIN];
      s = in_i[bit_idx(0, t, 0, TERMS, TIN) +: TIN];
      // an all-zero mask disables the term instead of making it constant 1
      term[t] = (|m) & (&(s | ~m));
    end
  end

  assign ynext_o = (|term) ^ inv_i;

endmodule

// File: rtl/sop_gate_array.sv
// Registered, programmable AND-OR(-invert) gate array with
// rise pulses, saturating toggle counters and hold.
module sop_gate_array
  import sop_gate_array_pkg::*;
#(
  parameter int CH    = 2,
  parameter int TERMS = 2,
  parameter int TIN   = 3,
  parameter int CNT_W = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CH*TERMS*TIN-1:0]         in_vec,
  input  logic                            hold,
  input  logic                            cfg_we,
  input  logic [idx_w(CH*TERMS)-1:0]      cfg_idx,
  input  logic [TIN-1:0]                  cfg_mask,
  input  logic                            cfg_inv_we,
  input  logic [CH-1:0]                   cfg_inv,
  input  logic                            cnt_clr,
  output logic [CH-1:0]                   y,
  output logic [CH-1:0]                   y_rise,
  output logic [CH*CNT_W-1:0]             tog_cnt,
  output logic                            cfg_err
);

  localparam int NT = CH * TERMS;
  localparam int NB = NT * TIN;
  localparam int CW = TERMS * TIN;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [NB-1:0]       mask_q, mask_d;
  logic [CH-1:0]       inv_q, inv_d;
  logic [CH-1:0]       y_q, y_d;
  logic [CH-1:0]       rise_q, rise_d;
  logic [CH*CNT_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [CH-1:0]       ynext;
  logic                idx_ok;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    sop_channel #(
      .TERMS (TERMS),
      .TIN   (TIN)
    ) u_ch (
      .in_i    (in_vec[c*CW +: CW]),
      .mask_i  (mask_q[c*CW +: CW]),
      .inv_i   (inv_q[c]),
      .ynext_o (ynext[c])
    );
  end

  assign idx_ok = 32'(cfg_idx) < NT;

  always_comb begin
    mask_d = mask_q;
    inv_d  = inv_q;
    y_d    = y_q;
    rise_d = '0;
    cnt_d  = cnt_q;
    err_d  = 1'b0;
    if (cfg_we) begin
      if (idx_ok) mask_d[32'(cfg_idx)*TIN +: TIN] = cfg_mask;
      else        err_d = 1'b1;
    end
    if (cfg_inv_we) inv_d = cfg_inv;
    if (!hold) begin
      y_d    = ynext;
      rise_d = ~y_q & ynext;
    end
    for (int c = 0; c < CH; c++) begin
      // clear wins over a same-cycle change
      if (cnt_clr)
        cnt_d[c*CNT_W +: CNT_W] = '0;
      else if (!hold && (ynext[c] != y_q[c])
               && (cnt_q[c*CNT_W +: CNT_W] != CMAX))
        cnt_d[c*CNT_W +: CNT_W] = cnt_q[c*CNT_W +: CNT_W] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= {NT{MASK_RST[TIN-1:0]}};
      inv_q  <= '0;
      y_q    <= '0;
      rise_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      inv_q  <= inv_d;
      y_q    <= y_d;
      rise_q <= rise_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign y       = y_q;
  assign y_rise  = rise_q;
  assign tog_cnt = cnt_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_sop_gate_array.sv
// Scoreboard bench for sop_gate_array against a behavioural model.
// A CH=3 instance covers out-of-range index writes.
module tb_sop_gate_array;

  localparam int CH = 2, TERMS = 2, TIN = 3, CNT_W = 4;
  localparam int NT = CH * TERMS;
  localparam int NB = NT * TIN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic [NB-1:0]     in_vec = '0;
  logic              hold = 1'b0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_idx = '0;
  logic [TIN-1:0]    cfg_mask = '0;
  logic              cfg_inv_we = 1'b0;
  logic [CH-1:0]     cfg_inv = '0;
  logic              cnt_clr = 1'b0;
  logic [CH-1:0]     y, y_rise;
  logic [CH*CNT_W-1:0] tog_cnt;
  logic              cfg_err;

  sop_gate_array #(
    .CH(CH), .TERMS(TERMS), .TIN(TIN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_vec(in_vec), .hold(hold),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mask(cfg_mask),
    .cfg_inv_we(cfg_inv_we), .cfg_inv(cfg_inv), .cnt_clr(cnt_clr),
    .y(y), .y_rise(y_rise), .tog_cnt(tog_cnt), .cfg_err(cfg_err)
  );

  logic        rst3 = 1'b1;
  logic [17:0] in3 = '1;
  logic        we3 = 1'b0;
  logic [2:0]  idx3 = '0;
  logic [2:0]  mask3 = '0;
  logic [2:0]  y3, rise3;
  logic [11:0] cnt3;
  logic        err3;

  sop_gate_array #(
    .CH(3), .TERMS(2), .TIN(3), .CNT_W(4)
  ) dut3 (
    .clk(clk), .rst(rst3), .in_vec(in3), .hold(1'b0),
    .cfg_we(we3), .cfg_idx(idx3), .cfg_mask(mask3),
    .cfg_inv_we(1'b0), .cfg_inv(3'b000), .cnt_clr(1'b0),
    .y(y3), .y_rise(rise3), .tog_cnt(cnt3), .cfg_err(err3)
  );

  typedef struct {
    logic [CH-1:0]       y;
    logic [CH-1:0]       rise;
    logic [CH*CNT_W-1:0] cnt;
    logic                err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // behavioural model state
  logic [TIN-1:0] m_mask[NT];
  logic [CH-1:0]  m_inv;
  logic [CH-1:0]  m_y, m_rise;
  int             m_cnt[CH];
  logic           m_err;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [CH-1:0] ref_ynext(input logic [NB-1:0] iv);
    logic [CH-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      logic sop;
      sop = 1'b0;
      for (int t = 0; t < TERMS; t++) begin
        int k;
        logic all;
        k = c * TERMS + t;
        all = (m_mask[k] != 0);
        for (int b = 0; b < TIN; b++)
          if (m_mask[k][b] && !iv[k * TIN + b]) all = 1'b0;
        sop = sop | all;
      end
      r[c] = sop ^ m_inv[c];
    end
    return r;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NT; k++) m_mask[k] = '1;
    m_inv = '0; m_y = '0; m_rise = '0; m_err = 1'b0;
    for (int c = 0; c < CH; c++) m_cnt[c] = 0;
  endfunction

  function automatic void model_step();
    logic [CH-1:0] yn;
    if (rst) begin
      model_reset();
      return;
    end
    yn = ref_ynext(in_vec);
    m_err = cfg_we && (int'(cfg_idx) >= NT);
    if (cfg_we && int'(cfg_idx) < NT) m_mask[cfg_idx] = cfg_mask;
    if (cfg_inv_we) m_inv = cfg_inv;
    for (int c = 0; c < CH; c++) begin
      if (cnt_clr) m_cnt[c] = 0;
      else if (!hold && yn[c] != m_y[c] && m_cnt[c] < 15)
        m_cnt[c] = m_cnt[c] + 1;
    end
    if (!hold) begin
      m_rise = ~m_y & yn;
      m_y = yn;
    end else begin
      m_rise = '0;
    end
  endfunction

  task automatic cyc();
    exp_t e;
    model_step();
    e.y = m_y;
    e.rise = m_rise;
    e.err = m_err;
    for (int c = 0; c < CH; c++)
      e.cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("y", y, e.y);
      chk("y_rise", y_rise, e.rise);
      chk("tog_cnt", tog_cnt, e.cnt);
      chk("cfg_err", cfg_err, e.err);
    end
  end

  task automatic wr_mask(input int idx, input logic [2:0] m);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_mask = m;
    cyc();
    cfg_we = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    in_vec = 12'h007;
    cyc(); cyc();
    in_vec = '0;
    wr_mask(2, 3'b011);
    wr_mask(3, 3'b011);
    in_vec = 12'h0C0;
    cyc(); cyc();
    in_vec = 12'h600;
    cyc();
    in_vec = '0;
    cyc();
    in_vec = 12'h007;
    wr_mask(0, 3'b000);
    cyc();
    wr_mask(0, 3'b111);
    cyc();
    in_vec = '0;
    cfg_inv_we = 1'b1; cfg_inv = 2'b01;
    cyc();
    cfg_inv_we = 1'b0;
    cyc();
    in_vec = '1;
    cyc(); cyc();
    in_vec = '0;
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    repeat (20) begin
      in_vec[2:0] = ~in_vec[2:0];
      cyc();
    end
    in_vec[2:0] = ~in_vec[2:0];
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    hold = 1'b1;
    repeat (5) begin
      in_vec = NB'($urandom);
      cyc();
    end
    hold = 1'b0;
    cyc();
    in_vec = NB'($urandom);
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_mask = 3'b000;
    cfg_inv_we = 1'b1; cfg_inv = 2'b10;
    rst = 1'b1;
    cyc();
    rst = 1'b0; cfg_we = 1'b0; cfg_inv_we = 1'b0;
    cyc();
    repeat (400) begin
      in_vec     = NB'($urandom);
      hold       = ($urandom_range(0, 4) == 0);
      cfg_we     = ($urandom_range(0, 5) == 0);
      cfg_idx    = 2'($urandom);
      cfg_mask   = 3'($urandom);
      cfg_inv_we = ($urandom_range(0, 7) == 0);
      cfg_inv    = 2'($urandom);
      cnt_clr    = ($urandom_range(0, 30) == 0);
      rst        = ($urandom_range(0, 80) == 0);
      cyc();
    end
    rst = 1'b0; hold = 1'b0; cfg_we = 1'b0;
    cfg_inv_we = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    // out-of-range index on a CH=3 array (6 terms, 3-bit index)
    rst3 = 1'b1;
    @(posedge clk); @(negedge clk);
    rst3 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("u3_y_rst_masks", y3, 3'b111);
    chk("u3_err_idle", err3, 0);
    we3 = 1'b1; idx3 = 3'd6; mask3 = 3'b000;
    @(posedge clk); @(negedge clk);
    we3 = 1'b0;
    chk("u3_err_idx6", err3, 1);
    chk("u3_y_idx6", y3, 3'b111);
    @(posedge clk); @(negedge clk);
    chk("u3_err_pulse_end", err3, 0);
    in3 = 18'h00007;
    we3 = 1'b1; idx3 = 3'd7; mask3 = 3'b000;
    @(posedge clk); @(negedge clk);
    chk("u3_err_idx7", err3, 1);
    idx3 = 3'd0;
    @(posedge clk); @(negedge clk);
    we3 = 1'b0;
    chk("u3_err_idx0", err3, 0);
    chk("u3_y_after_idx7", y3, 3'b001);
    @(posedge clk); @(negedge clk);
    chk("u3_y_term0_off", y3, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
